decoder_r32i: RTL and testbench

- Instruction-decode stage that drives the RV32I ALU.
- Turns a fetched 32-bit instruction into ALU codes, register indices, an immediate and operand-select/control flags.
- Sits between fetch and register-read/execute, with valid/ready handshakes on both sides.
- A 2-entry output buffer (output register plus skid slot) keeps in_ready a registered signal, so backpressure does not pass combinationally to fetch.

---
 rtl/r32i_pkg.sv | 62 ++++++
 rtl/decoder_r32i_comb.sv | 96 +++++++++
 rtl/decoder_r32i.sv | 111 +++++++++++
 tb/tb_decoder_r32i.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/r32i_pkg.sv
// Shared definitions for the RV32I decode stage: ALU operation codes,
// major opcodes, and the decoded bundle that travels from decode to execute.
// No ports; imported by decoder_r32i and decoder_r32i_comb.
package r32i_pkg;

  localparam int DATA_W = 32;
  localparam int REG_W  = 5;

  // ALU operation codes (SUB is the new member of the set)
  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SLT  = 4'd1;
  localparam logic [3:0] ALU_SLTU = 4'd2;
  localparam logic [3:0] ALU_AND  = 4'd3;
  localparam logic [3:0] ALU_OR   = 4'd4;
  localparam logic [3:0] ALU_XOR  = 4'd5;
  localparam logic [3:0] ALU_SSL  = 4'd6;
  localparam logic [3:0] ALU_SSR  = 4'd7;
  localparam logic [3:0] ALU_SRA  = 4'd8;
  localparam logic [3:0] ALU_CPY  = 4'd9;
  localparam logic [3:0] ALU_SUB  = 4'd10;

  // Major opcodes
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;

  localparam logic [6:0] F7_ZERO = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef struct packed {
    logic [3:0]        alucode;
    logic [REG_W-1:0]  rd;
    logic [REG_W-1:0]  rs1;
    logic [REG_W-1:0]  rs2;
    logic [DATA_W-1:0] imm;
    logic              a_pc;
    logic              b_imm;
    logic              wb_en;
    logic              mem_rd;
    logic              mem_wr;
    logic              illegal;
    logic [DATA_W-1:0] pc;
  } dec_bundle_t;

  // funct3 -> ALU code for the base (funct7 = 0) OP / OP-IMM encodings
  function automatic logic [3:0] f3_alu(input logic [2:0] f3);
    case (f3)
      3'b000:  f3_alu = ALU_ADD;
      3'b001:  f3_alu = ALU_SSL;
      3'b010:  f3_alu = ALU_SLT;
      3'b011:  f3_alu = ALU_SLTU;
      3'b100:  f3_alu = ALU_XOR;
      3'b101:  f3_alu = ALU_SSR;
      3'b110:  f3_alu = ALU_OR;
      default: f3_alu = ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/decoder_r32i_comb.sv
// Purpose: purely combinational RV32I instruction+pc -> dec_bundle_t decode.
// Latency: 0 cycles. Backpressure: none, no state.
// Ports: instr/pc in; bundle out (all payload fields of the decode stage).
module decoder_r32i_comb
  import r32i_pkg::*;
(
  input  logic [31:0]       instr,
  input  logic [DATA_W-1:0] pc,
  output dec_bundle_t       bundle
);

  logic [6:0] opcode;
  logic [2:0] f3;
  logic [6:0] f7;
  logic [4:0] rd;
  logic       legal;
  logic       wb;

  assign opcode = instr[6:0];
  assign rd     = instr[11:7];
  assign f3     = instr[14:12];
  assign f7     = instr[31:25];

  always_comb begin
    bundle         = '0;
    bundle.rd      = rd;
    bundle.rs1     = instr[19:15];
    bundle.rs2     = instr[24:20];
    bundle.pc      = pc;
    bundle.alucode = ALU_ADD;
    legal          = 1'b1;
    wb             = 1'b0;

    case (opcode)
      OPC_OP: begin
        wb = 1'b1;
        if (f7 == F7_ZERO)                    bundle.alucode = f3_alu(f3);
        else if (f7 == F7_ALT && f3 == 3'b000) bundle.alucode = ALU_SUB;
        else if (f7 == F7_ALT && f3 == 3'b101) bundle.alucode = ALU_SRA;
        else                                   legal = 1'b0;
      end
      OPC_OPIMM: begin
        wb             = 1'b1;
        bundle.b_imm   = 1'b1;
        bundle.alucode = f3_alu(f3);
        bundle.imm     = {{20{instr[31]}}, instr[31:20]};
        // Shifts carry a 5-bit shamt in the immediate slot; upper bits are funct7.
        if (f3 == 3'b001) begin
          bundle.imm = {27'd0, instr[24:20]};
          if (f7 != F7_ZERO) legal = 1'b0;
        end else if (f3 == 3'b101) begin
          bundle.imm = {27'd0, instr[24:20]};
          if (f7 == F7_ZERO)     bundle.alucode = ALU_SSR;
          else if (f7 == F7_ALT) bundle.alucode = ALU_SRA;
          else                   legal = 1'b0;
        end
      end
      OPC_LUI: begin
        wb             = 1'b1;
        bundle.alucode = ALU_CPY;
        bundle.b_imm   = 1'b1;
        bundle.imm     = {instr[31:12], 12'd0};
      end
      OPC_AUIPC: begin
        wb           = 1'b1;
        bundle.a_pc  = 1'b1;
        bundle.b_imm = 1'b1;
        bundle.imm   = {instr[31:12], 12'd0};
      end
      OPC_LOAD: begin
        wb            = 1'b1;
        bundle.b_imm  = 1'b1;
        bundle.mem_rd = 1'b1;
        bundle.imm    = {{20{instr[31]}}, instr[31:20]};
        if (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111) legal = 1'b0;
      end
      OPC_STORE: begin
        bundle.b_imm  = 1'b1;
        bundle.mem_wr = 1'b1;
        bundle.imm    = {{20{instr[31]}}, instr[31:25], instr[11:7]};
        if (f3[2] || f3 == 3'b011) legal = 1'b0;
      end
      default: legal = 1'b0;
    endcase

    if (!legal) begin
      bundle.alucode = ALU_ADD;
      bundle.mem_rd  = 1'b0;
      bundle.mem_wr  = 1'b0;
      bundle.illegal = 1'b1;
    end
    // x0 is never written, so suppress writeback there.
    bundle.wb_en = wb && legal && (rd != 5'd0);
  end

endmodule

// File: rtl/decoder_r32i.sv
// Purpose: RV32I decode stage with valid/ready on both sides (optional macro DECODER_ILLEGAL_CNT_EN adds illegal_cnt).
// Latency: 1 cycle from input accept to out_valid.
// Backpressure: output register + skid slot; in_ready is registered (= !skid_valid), never combinational from out_ready.
// Ports: clock/reset (sync, active-high), flush, in_* handshake+instr+pc, out_* handshake+decoded payload.
module decoder_r32i
  import r32i_pkg::*;
#(
  parameter int dataW = 32,
  parameter int regW  = 5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [dataW-1:0] in_pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       out_alucode,
  output logic [regW-1:0]  out_rd,
  output logic [regW-1:0]  out_rs1,
  output logic [regW-1:0]  out_rs2,
  output logic [dataW-1:0] out_imm,
  output logic             out_a_pc,
  output logic             out_b_imm,
  output logic             out_wb_en,
  output logic             out_mem_rd,
  output logic             out_mem_wr,
  output logic             out_illegal,
`ifdef DECODER_ILLEGAL_CNT_EN
  output logic [15:0]      illegal_cnt,
`endif
  output logic [dataW-1:0] out_pc
);

  dec_bundle_t dec;
  dec_bundle_t out_q;
  dec_bundle_t skid_q;
  logic        skid_valid;
  logic        acc;
  logic        xfer;
  logic        out_free;

  decoder_r32i_comb u_comb (
    .instr  (in_instr),
    .pc     (in_pc),
    .bundle (dec)
  );

  assign acc      = in_valid && in_ready;
  assign xfer     = out_valid && out_ready;
  assign out_free = !out_valid || xfer;

  always_ff @(posedge clock) begin
    if (reset) begin
      out_q      <= '0;
      skid_q     <= '0;
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
      in_ready   <= 1'b1;
    end else if (flush) begin
      // Flush wins over a same-cycle accept; that instruction is dropped.
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
      in_ready   <= 1'b1;
    end else if (out_free) begin
      if (skid_valid) begin
        // in_ready is 0 while the skid is occupied, so no accept competes here.
        out_q      <= skid_q;
        out_valid  <= 1'b1;
        skid_valid <= 1'b0;
        in_ready   <= 1'b1;
      end else if (acc) begin
        out_q     <= dec;
        out_valid <= 1'b1;
      end else begin
        out_valid <= 1'b0;
      end
    end else if (acc) begin
      skid_q     <= dec;
      skid_valid <= 1'b1;
      in_ready   <= 1'b0;
    end
  end

`ifdef DECODER_ILLEGAL_CNT_EN
  // Counted at input accept, so flushed illegal bundles are included.
  always_ff @(posedge clock) begin
    if (reset) begin
      illegal_cnt <= 16'd0;
    end else if (acc && dec.illegal && illegal_cnt != 16'hFFFF) begin
      illegal_cnt <= illegal_cnt + 16'd1;
    end
  end
`endif

  assign out_alucode = out_q.alucode;
  assign out_rd      = out_q.rd;
  assign out_rs1     = out_q.rs1;
  assign out_rs2     = out_q.rs2;
  assign out_imm     = out_q.imm;
  assign out_a_pc    = out_q.a_pc;
  assign out_b_imm   = out_q.b_imm;
  assign out_wb_en   = out_q.wb_en;
  assign out_mem_rd  = out_q.mem_rd;
  assign out_mem_wr  = out_q.mem_wr;
  assign out_illegal = out_q.illegal;
  assign out_pc      = out_q.pc;

endmodule

// File: tb/tb_decoder_r32i.sv
module tb_decoder_r32i;
  import r32i_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_alucode;
  logic [4:0]  out_rd, out_rs1, out_rs2;
  logic [31:0] out_imm;
  logic        out_a_pc, out_b_imm, out_wb_en, out_mem_rd, out_mem_wr, out_illegal;
  logic [31:0] out_pc;
`ifdef DECODER_ILLEGAL_CNT_EN
  logic [15:0] illegal_cnt;
`endif

  int total = 0;
  int bad   = 0;

  decoder_r32i dut (
    .clock       (clock),
    .reset       (reset),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_instr    (in_instr),
    .in_pc       (in_pc),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_alucode (out_alucode),
    .out_rd      (out_rd),
    .out_rs1     (out_rs1),
    .out_rs2     (out_rs2),
    .out_imm     (out_imm),
    .out_a_pc    (out_a_pc),
    .out_b_imm   (out_b_imm),
    .out_wb_en   (out_wb_en),
    .out_mem_rd  (out_mem_rd),
    .out_mem_wr  (out_mem_wr),
    .out_illegal (out_illegal),
`ifdef DECODER_ILLEGAL_CNT_EN
    .illegal_cnt (illegal_cnt),
`endif
    .out_pc      (out_pc)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one clock; sample point is 1 time unit after the rising edge.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic [31:0] ins, input logic [31:0] pc);
    in_valid = 1'b1;
    in_instr = ins;
    in_pc    = pc;
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0; out_ready = 1'b1;
    step(); step();
    reset = 1'b0;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_in_ready",  32'(in_ready),  1);
    chk("rst_imm",       out_imm,        0);
    chk("rst_wb_en",     32'(out_wb_en), 0);
`ifdef DECODER_ILLEGAL_CNT_EN
    chk("rst_cnt", 32'(illegal_cnt), 0);
`endif

    // addi x1,x0,5
    drive(32'h00500093, 32'h100); step();
    chk("addi_valid", 32'(out_valid), 1);
    chk("addi_alu",   32'(out_alucode), 32'(ALU_ADD));
    chk("addi_rd",    32'(out_rd), 1);
    chk("addi_rs1",   32'(out_rs1), 0);
    chk("addi_imm",   out_imm, 5);
    chk("addi_bimm",  32'(out_b_imm), 1);
    chk("addi_wb",    32'(out_wb_en), 1);
    chk("addi_pc",    out_pc, 32'h100);

    // sub x3,x1,x2
    drive(32'h402081B3, 32'h104); step();
    chk("sub_alu",  32'(out_alucode), 32'(ALU_SUB));
    chk("sub_rs1",  32'(out_rs1), 1);
    chk("sub_rs2",  32'(out_rs2), 2);
    chk("sub_rd",   32'(out_rd), 3);
    chk("sub_bimm", 32'(out_b_imm), 0);

    // srai x5,x6,3
    drive(32'h40335293, 32'h108); step();
    chk("srai_alu", 32'(out_alucode), 32'(ALU_SRA));
    chk("srai_imm", out_imm, 3);

    // lui x7,0x12345
    drive(32'h123453B7, 32'h10C); step();
    chk("lui_alu",  32'(out_alucode), 32'(ALU_CPY));
    chk("lui_imm",  out_imm, 32'h12345000);
    chk("lui_bimm", 32'(out_b_imm), 1);
    chk("lui_wb",   32'(out_wb_en), 1);

    // addi x1,x0,-1 : sign extension
    drive(32'hFFF00093, 32'h110); step();
    chk("addineg_imm", out_imm, 32'hFFFFFFFF);

    // auipc x1,1
    drive(32'h00001097, 32'h114); step();
    chk("auipc_apc", 32'(out_a_pc), 1);
    chk("auipc_imm", out_imm, 32'h1000);

    // lw x4,8(x2)
    drive(32'h00812203, 32'h118); step();
    chk("lw_memrd", 32'(out_mem_rd), 1);
    chk("lw_wb",    32'(out_wb_en), 1);
    chk("lw_imm",   out_imm, 8);

    // sw x5,12(x1)
    drive(32'h0050A623, 32'h11C); step();
    chk("sw_memwr", 32'(out_mem_wr), 1);
    chk("sw_wb",    32'(out_wb_en), 0);
    chk("sw_imm",   out_imm, 12);
    chk("sw_rs2",   32'(out_rs2), 5);

    // add x0,x1,x2 : writeback suppressed for x0
    drive(32'h00208033, 32'h120); step();
    chk("rd0_wb",  32'(out_wb_en), 0);
    chk("rd0_ill", 32'(out_illegal), 0);

    // all-ones word is illegal
    drive(32'hFFFFFFFF, 32'h124); step();
    chk("ill_flag", 32'(out_illegal), 1);
    chk("ill_wb",   32'(out_wb_en), 0);
    chk("ill_alu",  32'(out_alucode), 32'(ALU_ADD));
    chk("ill_valid", 32'(out_valid), 1);
`ifdef DECODER_ILLEGAL_CNT_EN
    chk("ill_cnt1", 32'(illegal_cnt), 1);
`endif

    // slli with funct7=0100000 is illegal
    drive(32'h40109093, 32'h128); step();
    chk("slli_ill", 32'(out_illegal), 1);
`ifdef DECODER_ILLEGAL_CNT_EN
    chk("ill_cnt2", 32'(illegal_cnt), 2);
`endif

    // drain
    in_valid = 1'b0; step();
    chk("drain_valid", 32'(out_valid), 0);

    // Backpressure: A, B pushed while consumer stalls, C held by source
    out_ready = 1'b0;
    drive(32'h00100093, 32'h200); step();
    chk("bp_a_valid", 32'(out_valid), 1);
    chk("bp_a_rdy",   32'(in_ready), 1);
    drive(32'h00200113, 32'h204); step();
    chk("bp_b_rdy",   32'(in_ready), 0);
    chk("bp_b_head",  out_imm, 1);
    drive(32'h00300193, 32'h208); step();
    chk("bp_hold_imm", out_imm, 1);
    chk("bp_hold_pc",  out_pc, 32'h200);
    chk("bp_hold_rdy", 32'(in_ready), 0);
    out_ready = 1'b1; step();
    chk("bp_out_b",  out_imm, 2);
    chk("bp_b_pc",   out_pc, 32'h204);
    chk("bp_rdy_up", 32'(in_ready), 1);
    step();
    chk("bp_out_c",  out_imm, 3);
    chk("bp_c_pc",   out_pc, 32'h208);
    in_valid = 1'b0; step();
    chk("bp_nodup", 32'(out_valid), 0);

    // Flush with output register and skid both full
    out_ready = 1'b0;
    drive(32'h00400213, 32'h300); step();
    drive(32'h00500293, 32'h304); step();
    chk("fl_full_rdy", 32'(in_ready), 0);
    drive(32'h00600313, 32'h308); flush = 1'b1; step();
    chk("fl_valid", 32'(out_valid), 0);
    chk("fl_rdy",   32'(in_ready), 1);
    // Flush with an accepting illegal instruction: dropped but counted
    drive(32'hFFFFFFFF, 32'h30C); step();
    chk("fl_drop_valid", 32'(out_valid), 0);
`ifdef DECODER_ILLEGAL_CNT_EN
    chk("fl_cnt3", 32'(illegal_cnt), 3);
`endif
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1; step();
    chk("fl_after_valid", 32'(out_valid), 0);

    // Mid-stream reset with both slots full
    out_ready = 1'b0;
    drive(32'h00700393, 32'h400); step();
    drive(32'h00800413, 32'h404); step();
    in_valid = 1'b0; reset = 1'b1; step();
    reset = 1'b0;
    chk("mrst_valid", 32'(out_valid), 0);
    chk("mrst_rdy",   32'(in_ready), 1);
    chk("mrst_imm",   out_imm, 0);
    chk("mrst_pc",    out_pc, 0);
`ifdef DECODER_ILLEGAL_CNT_EN
    chk("mrst_cnt", 32'(illegal_cnt), 0);
`endif
    step();
    chk("mrst_stay", 32'(out_valid), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
